// File: rtl/rip_fifo_unpack.sv
// rip_fifo_unpack: splits show-ahead FIFO words into OUT_WIDTH beats on a valid/ready stream.
// Define RIP_FIFO_UNPACK_MSB_FIRST_EN to emit beats most-significant slice first.
module rip_fifo_unpack #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] SEND  = 1'b1;

    logic [0:0]          state;
    logic [IN_WIDTH-1:0] word;
    logic [BW-1:0]       beat;
    logic [BW-1:0]       slice_idx;
    logic                transfer;

    assign m_valid  = (state == SEND);
    assign m_last   = m_valid && (beat == LAST_BEAT);
    assign transfer = m_valid && m_ready;

    // Pop when idle, or on the final beat so the next word follows without a bubble.
    assign fifo_rd_en = !rst && !fifo_empty && ((state == EMPTY) || (transfer && m_last));

`ifdef RIP_FIFO_UNPACK_MSB_FIRST_EN
    assign slice_idx = LAST_BEAT - beat;
`else
    assign slice_idx = beat;
`endif

    always_comb begin
        m_data = '0;
        if (m_valid) begin
            m_data = word[int'(slice_idx) * OUT_WIDTH +: OUT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            beat  <= '0;
            word  <= '0;
        end else if (fifo_rd_en) begin
            state <= SEND;
            beat  <= '0;
            word  <= fifo_data;
        end else if (transfer) begin
            if (m_last) begin
                state <= EMPTY;
            end else begin
                beat <= beat + BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rip_fifo_unpack.sv
// tb_rip_fifo_unpack: table-driven and scoreboard bench for rip_fifo_unpack (128 -> 32 bits).
// Honours RIP_FIFO_UNPACK_MSB_FIRST_EN so the expected beat order follows the build.
module tb_rip_fifo_unpack;
    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [127:0]      word;
        logic [7:0]        ready_pat;
        logic [3:0][31:0]  beats;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         fifo_empty;
    logic [127:0] fifo_data;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic         m_last;

    logic [127:0] fifo_q[$];
    beat_t        exp_q[$];
    vec_t         vecs[4];

    int n_cmp = 0;
    int n_fail = 0;
    int rd_total = 0;
    int chained = 0;

    logic        prev_hold;
    logic        s_valid, s_rd, s_last, s_xfer;
    logic [31:0] s_data;

    rip_fifo_unpack #(.IN_WIDTH(128), .OUT_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic push_word(input vec_t v);
        beat_t b;
        fifo_q.push_back(v.word);
        for (int k = 0; k < 4; k++) begin
`ifdef RIP_FIFO_UNPACK_MSB_FIRST_EN
            b.data = v.beats[3-k];
`else
            b.data = v.beats[k];
`endif
            b.last = (k == 3);
            exp_q.push_back(b);
        end
    endtask

    // One clock: drive inputs, sample mid-cycle, score transfers, advance the FIFO model.
    task automatic step(input logic ready, input logic do_rst);
        logic [127:0] tmp_w;
        beat_t        tmp_b;
        rst        = do_rst;
        m_ready    = ready;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 128'h0 : fifo_q[0];
        #1;
        if (prev_hold) check("valid_held", m_valid, 1);
        s_valid = m_valid;
        s_rd    = fifo_rd_en;
        s_last  = m_last;
        s_data  = m_data;
        s_xfer  = m_valid && m_ready;
        check("rd_en_legal", s_rd && (fifo_empty || do_rst), 0);
        if (s_xfer && !do_rst) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_beat: got 0x%0h, want no beat", s_data);
            end else begin
                tmp_b = exp_q.pop_front();
                check("beat_data", s_data, tmp_b.data);
                check("beat_last", s_last, tmp_b.last);
            end
        end
        if (s_rd) begin
            rd_total++;
            if (s_xfer && s_last) chained++;
            if (fifo_q.size() > 0) tmp_w = fifo_q.pop_front();
        end
        prev_hold = s_valid && !s_xfer && !do_rst;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input logic [7:0] pat, input int budget,
                         output int xfers, output int span, output int first);
        int last_c;
        xfers  = 0;
        first  = -1;
        last_c = -1;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            step(pat[c % 8], 1'b0);
            if (s_xfer) begin
                xfers++;
                if (first < 0) first = c;
                last_c = c;
            end
        end
        span = (first < 0) ? 0 : last_c - first + 1;
        check("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        int xf, sp, fi, rd0, ch0, cnt;
        logic any_v, any_rd;
        logic [31:0] held;

        vecs[0].word = 128'h44444444_33333333_22222222_11111111;
        vecs[0].ready_pat = 8'hFF;
        vecs[0].beats = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        vecs[1].word = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        vecs[1].ready_pat = 8'b1010_1010;
        vecs[1].beats = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
        vecs[2].word = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
        vecs[2].ready_pat = 8'b0011_0110;
        vecs[2].beats = {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[3].word = 128'h00000001_80000000_7FFFFFFF_FFFFFFFE;
        vecs[3].ready_pat = 8'b1100_0001;
        vecs[3].beats = {32'h00000001, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};

        rst = 1'b1;
        m_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_data = '0;
        prev_hold = 1'b0;

        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("reset_valid", m_valid, 0);
        check("reset_last", m_last, 0);
        check("reset_data", m_data, 0);
        check("reset_rd_en", fifo_rd_en, 0);

        // Idle FIFO after reset: nothing may be popped or emitted.
        any_v = 1'b0;
        any_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            any_v  |= s_valid;
            any_rd |= s_rd;
        end
        check("idle_valid", any_v, 0);
        check("idle_rd_en", any_rd, 0);

        // Single word, full throughput, one-cycle load latency.
        push_word(vecs[0]);
        rd0 = rd_total;
        step(1'b1, 1'b0);
        check("load_rd_en", s_rd, 1);
        check("load_valid", s_valid, 0);
        drain(8'hFF, 20, xf, sp, fi);
        check("single_beats", xf, 4);
        check("single_span", sp, 4);
        check("single_first", fi, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("single_after_valid", s_valid, 0);
        check("single_pops", rd_total - rd0, 1);

        // Table of words with varied backpressure patterns.
        foreach (vecs[i]) begin
            rd0 = rd_total;
            push_word(vecs[i]);
            drain(vecs[i].ready_pat, 40, xf, sp, fi);
            check("table_beats", xf, 4);
            check("table_pops", rd_total - rd0, 1);
        end

        // Two queued words must stream back to back.
        rd0 = rd_total;
        ch0 = chained;
        push_word(vecs[0]);
        push_word(vecs[1]);
        drain(8'hFF, 30, xf, sp, fi);
        check("pair_beats", xf, 8);
        check("pair_span", sp, 8);
        check("pair_chained_pop", chained - ch0, 1);
        check("pair_pops", rd_total - rd0, 2);

        // Backpressure on the second beat holds data steady.
        push_word(vecs[0]);
        cnt = 0;
        for (int c = 0; c < 10 && cnt < 1; c++) begin
            step(1'b1, 1'b0);
            if (s_xfer) cnt++;
        end
        check("stall_setup", cnt, 1);
        held = exp_q[0].data;
        rd0 = rd_total;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("stall_valid", s_valid, 1);
            check("stall_data", s_data, held);
        end
        check("stall_no_pop", rd_total - rd0, 0);
        drain(8'hFF, 20, xf, sp, fi);
        check("stall_resume_beats", xf, 3);

        // Reset mid-word discards the remaining beats.
        push_word(vecs[0]);
        cnt = 0;
        for (int c = 0; c < 10 && cnt < 2; c++) begin
            step(1'b1, 1'b0);
            if (s_xfer) cnt++;
        end
        check("rst_setup", cnt, 2);
        step(1'b0, 1'b1);
        check("rst_cycle_rd_en", s_rd, 0);
        exp_q.delete();
        step(1'b1, 1'b0);
        check("rst_after_valid", s_valid, 0);
        any_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            any_v |= s_valid;
        end
        check("rst_no_more_beats", any_v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
